// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-high glyphs {g,f,e,d,c,b,a},
// capture FSM encoding and the decoder result payload.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       error;
  } dec_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Display bus and capture output channel of seg7_capture.
// master drives the pins and out_ready; slave is the capture block.
interface seg7_capture_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   dig_n;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_digit;
  logic [3:0]          out_value;
  logic                out_blank;
  logic                out_error;
  logic [4*DIGITS-1:0] snapshot;
  logic                overflow;

  modport master (
    output seg_n, dig_n, out_ready,
    input  out_valid, out_digit, out_value, out_blank, out_error, snapshot, overflow
  );

  modport slave (
    input  seg_n, dig_n, out_ready,
    output out_valid, out_digit, out_value, out_blank, out_error, snapshot, overflow
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational glyph decoder: active-high segment pattern to value/blank/error.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output dec_t       dec_c
);

  always_comb begin
    dec_c = '0;
    case (pattern)
      SEG_0:     dec_c.value = 4'h0;
      SEG_1:     dec_c.value = 4'h1;
      SEG_2:     dec_c.value = 4'h2;
      SEG_3:     dec_c.value = 4'h3;
      SEG_4:     dec_c.value = 4'h4;
      SEG_5:     dec_c.value = 4'h5;
      SEG_6:     dec_c.value = 4'h6;
      SEG_7:     dec_c.value = 4'h7;
      SEG_8:     dec_c.value = 4'h8;
      SEG_9:     dec_c.value = 4'h9;
      SEG_A:     dec_c.value = 4'hA;
      SEG_B:     dec_c.value = 4'hB;
      SEG_C:     dec_c.value = 4'hC;
      SEG_D:     dec_c.value = 4'hD;
      SEG_E:     dec_c.value = 4'hE;
      SEG_F:     dec_c.value = 4'hF;
      SEG_BLANK: dec_c.blank = 1'b1;
      default:   dec_c.error = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Recovers digits from a multiplexed active-low 7-segment bus: synchronize,
// qualify by stability, decode, and hand off through a one-entry buffer.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input logic           clk,
  input logic           reset,
  seg7_capture_if.slave bus
);

  localparam int unsigned SW = DIGITS + 7;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 2);

  logic [SW-1:0]       meta;
  logic [SW-1:0]       sync;
  state_t              state;
  logic [CW-1:0]       cnt;
  logic                valid;
  logic [DW-1:0]       digit;
  logic [3:0]          value;
  logic                blank;
  logic                error;
  logic [4*DIGITS-1:0] snap;
  logic                ovf;

  logic [DIGITS-1:0]   act;
  logic [6:0]          seg_on;
  logic                same;
  logic                qual;
  logic                capture;
  logic [DW-1:0]       idx;
  dec_t                dec;

  // The sample entering stage 2 is compared against stage 2, so a pin change
  // clears cnt on the edge that makes it visible in the synchronized sample.
  assign act     = ~meta[SW-1:7];
  assign seg_on  = ~meta[6:0];
  assign same    = (meta == sync);
  assign qual    = (act != '0) && ((act & (act - DIGITS'(1))) == '0);
  assign capture = qual && same && (state == ST_STABLE) && (cnt == CNT_CAP);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (act[i]) idx = DW'(i);
    end
  end

  seg7_decode u_decode (
    .pattern (seg_on),
    .dec_c   (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= '1;
      sync  <= '1;
      state <= ST_WAIT;
      cnt   <= '0;
      valid <= 1'b0;
      digit <= '0;
      value <= '0;
      blank <= 1'b0;
      error <= 1'b0;
      snap  <= '0;
      ovf   <= 1'b0;
    end else begin
      meta <= {bus.dig_n, bus.seg_n};
      sync <= meta;

      if (!qual) begin
        cnt   <= '0;
        state <= ST_WAIT;
      end else begin
        if (!same)               cnt <= '0;
        else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);

        case (state)
          ST_WAIT:   state <= ST_STABLE;
          ST_STABLE: begin
            if (!same)                state <= ST_WAIT;
            else if (cnt == CNT_CAP)  state <= ST_HOLD;
          end
          ST_HOLD:   if (!same) state <= ST_WAIT;
          default:   state <= ST_WAIT;
        endcase
      end

      if (valid && bus.out_ready) valid <= 1'b0;

      // Snapshot tracks every legal capture even when the buffer overflows.
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (capture && !dec.error && act[i]) snap[4*i +: 4] <= dec.value;
      end

      if (capture) begin
        if (!valid || bus.out_ready) begin
          valid <= 1'b1;
          digit <= idx;
          value <= dec.value;
          blank <= dec.blank;
          error <= dec.error;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = valid;
  assign bus.out_digit = digit;
  assign bus.out_value = value;
  assign bus.out_blank = blank;
  assign bus.out_error = error;
  assign bus.snapshot  = snap;
  assign bus.overflow  = ovf;

endmodule
